// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port synchronous RAM between the CPU data
// port (read/write) and the video fetch port (read-only). One access is in
// flight at a time with a fixed three-cycle latency. Ties are broken
// round-robin, and a starvation counter hands video absolute priority once it
// has waited long enough.
module mem_arbiter #(
  parameter int AW           = 16,
  parameter int DW           = 8,
  parameter int VID_MAX_WAIT = 8
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_address,
  input  logic [DW-1:0] cpu_data_o,
  output logic [DW-1:0] cpu_data_i,
  output logic          cpu_ack,
  input  logic          vid_req,
  input  logic [AW-1:0] vid_address,
  output logic [DW-1:0] vid_data,
  output logic          vid_ack,
  output logic [AW-1:0] mem_address,
  output logic [DW-1:0] mem_data_o,
  input  logic [DW-1:0] mem_data_i,
  output logic          mem_we,
  output logic          busy
);

  localparam int WW = $clog2(VID_MAX_WAIT) + 1;
  localparam logic [WW-1:0] WaitMax = WW'(VID_MAX_WAIT);

  typedef enum logic [1:0] {IDLE, ACC, RESP} state_e;
  typedef enum logic {OWNER_CPU, OWNER_VID} owner_e;

  state_e        state_q, state_d;
  owner_e        owner_q, owner_d;
  owner_e        last_q, last_d;
  logic          isWrite_q, isWrite_d;
  logic [WW-1:0] waitCnt_q, waitCnt_d;
  logic [AW-1:0] memAddress_q, memAddress_d;
  logic [DW-1:0] memDataOut_q, memDataOut_d;
  logic          memWe_q, memWe_d;
  logic [DW-1:0] cpuData_q, cpuData_d;
  logic [DW-1:0] vidData_q, vidData_d;
  logic          cpuAck_q, cpuAck_d;
  logic          vidAck_q, vidAck_d;
  logic          grantCpu, grantVid;

  // Decide who wins the RAM in IDLE: a lone requester always wins; on a tie a
  // starved video port wins outright, otherwise whoever was not served last.
  always_comb begin
    grantCpu = 1'b0;
    grantVid = 1'b0;
    if (state_q == IDLE) begin
      if (cpu_req && vid_req) begin
        if (waitCnt_q >= WaitMax) begin
          grantVid = 1'b1;
        end else if (last_q == OWNER_VID) begin
          grantCpu = 1'b1;
        end else begin
          grantVid = 1'b1;
        end
      end else if (cpu_req) begin
        grantCpu = 1'b1;
      end else if (vid_req) begin
        grantVid = 1'b1;
      end
    end
  end

  // Next-state logic: IDLE launches the granted access, ACC lets the RAM
  // sample address/we, RESP captures read data and raises the owner's ack.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_d       = last_q;
    isWrite_d    = isWrite_q;
    memAddress_d = memAddress_q;
    memDataOut_d = memDataOut_q;
    memWe_d      = memWe_q;
    cpuData_d    = cpuData_q;
    vidData_d    = vidData_q;
    cpuAck_d     = 1'b0;
    vidAck_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (grantCpu) begin
          owner_d      = OWNER_CPU;
          isWrite_d    = cpu_we;
          memAddress_d = cpu_address;
          memDataOut_d = cpu_data_o;
          memWe_d      = cpu_we;
          state_d      = ACC;
        end else if (grantVid) begin
          owner_d      = OWNER_VID;
          isWrite_d    = 1'b0;
          memAddress_d = vid_address;
          memWe_d      = 1'b0;
          state_d      = ACC;
        end
      end
      ACC: begin
        memWe_d = 1'b0;
        state_d = RESP;
      end
      RESP: begin
        if (owner_q == OWNER_CPU) begin
          cpuAck_d = 1'b1;
          if (!isWrite_q) begin
            cpuData_d = mem_data_i;
          end
        end else begin
          vidAck_d  = 1'b1;
          vidData_d = mem_data_i;
        end
        last_d  = owner_q;
        state_d = IDLE;
      end
      default: begin
        memWe_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // Starvation counter: counts cycles video is kept waiting, holds while video
  // owns the RAM, and clears once video is granted or withdraws its request.
  always_comb begin
    waitCnt_d = waitCnt_q;
    if (!vid_req || grantVid) begin
      waitCnt_d = '0;
    end else if (!(state_q != IDLE && owner_q == OWNER_VID)) begin
      if (waitCnt_q < WaitMax) begin
        waitCnt_d = waitCnt_q + WW'(1);
      end
    end
  end

  // State register; reset aborts any access in flight without producing an ack.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      owner_q      <= OWNER_CPU;
      last_q       <= OWNER_VID;
      isWrite_q    <= 1'b0;
      waitCnt_q    <= '0;
      memAddress_q <= '0;
      memDataOut_q <= '0;
      memWe_q      <= 1'b0;
      cpuData_q    <= '0;
      vidData_q    <= '0;
      cpuAck_q     <= 1'b0;
      vidAck_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_q       <= last_d;
      isWrite_q    <= isWrite_d;
      waitCnt_q    <= waitCnt_d;
      memAddress_q <= memAddress_d;
      memDataOut_q <= memDataOut_d;
      memWe_q      <= memWe_d;
      cpuData_q    <= cpuData_d;
      vidData_q    <= vidData_d;
      cpuAck_q     <= cpuAck_d;
      vidAck_q     <= vidAck_d;
    end
  end

  assign mem_address = memAddress_q;
  assign mem_data_o  = memDataOut_q;
  assign mem_we      = memWe_q;
  assign cpu_data_i  = cpuData_q;
  assign vid_data    = vidData_q;
  assign cpu_ack     = cpuAck_q;
  assign vid_ack     = vidAck_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: drives directed and random traffic into mem_arbiter with a
// behavioural RAM attached, predicts every ack from an access-level model and
// checks the DUT against it through a scoreboard queue.
module tb_mem_arbiter;

  localparam int AW   = 16;
  localparam int DW   = 8;
  localparam int MAXW = 2;

  logic          clock;
  logic          reset_n;
  logic          cpu_req, cpu_we;
  logic [AW-1:0] cpu_address;
  logic [DW-1:0] cpu_data_o, cpu_data_i;
  logic          cpu_ack;
  logic          vid_req;
  logic [AW-1:0] vid_address;
  logic [DW-1:0] vid_data;
  logic          vid_ack;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_data_o, mem_data_i;
  logic          mem_we, busy;

  mem_arbiter #(.AW(AW), .DW(DW), .VID_MAX_WAIT(MAXW)) dut (
    .clock(clock), .reset_n(reset_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_address(cpu_address),
    .cpu_data_o(cpu_data_o), .cpu_data_i(cpu_data_i), .cpu_ack(cpu_ack),
    .vid_req(vid_req), .vid_address(vid_address), .vid_data(vid_data), .vid_ack(vid_ack),
    .mem_address(mem_address), .mem_data_o(mem_data_o), .mem_data_i(mem_data_i),
    .mem_we(mem_we), .busy(busy)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic logic [7:0] initVal(input int i);
    return 8'((i * 37 + 11) & 255);
  endfunction

  // Behavioural synchronous RAM: preloaded on the first edge, then writes on
  // mem_we and returns read data one cycle after the address.
  logic [7:0] ram [0:511];
  logic       ramLoaded = 1'b0;
  always @(posedge clock) begin
    if (!ramLoaded) begin
      for (int i = 0; i < 512; i++) ram[i] <= initVal(i);
      ramLoaded <= 1'b1;
    end else begin
      if (mem_we) ram[mem_address[8:0]] <= mem_data_o;
      mem_data_i <= ram[mem_address[8:0]];
    end
  end

  typedef struct {
    bit         isVid;
    bit         isWrite;
    logic [7:0] data;
    int         ackEdge;
  } exp_t;

  exp_t       expQ[$];
  int         checks = 0;
  int         failures = 0;
  int         edgeCnt = 0;
  logic [7:0] modelMem [0:511];
  int         mBusy = 0;
  bit         mOwnerVid = 0;
  bit         mLastVid = 1;
  bit         mIsWrite = 0;
  logic [7:0] mData = 0;
  int         mWait = 0;
  logic [7:0] expCpuData = 0;
  logic [7:0] expVidData = 0;
  logic [15:0] expMemAddr = 0;
  bit         expMemWe = 0;
  bit         expBusy = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h (edge %0d)", name, act, req, edgeCnt);
    end
  endtask

  // Access-level reference: the RAM is free or busy for two more edges after
  // a grant; grants follow the tie-break rules and each grant schedules one
  // ack two edges later carrying the model memory contents.
  task automatic modelStep();
    bit   gCpu, gVid;
    exp_t t;
    edgeCnt++;
    expMemWe = 0;
    if (!reset_n) begin
      while (expQ.size() > 0 && expQ[expQ.size()-1].ackEdge >= edgeCnt) void'(expQ.pop_back());
      mBusy = 0; mLastVid = 1; mWait = 0;
      expCpuData = 0; expVidData = 0; expMemAddr = 0; expBusy = 0;
      return;
    end
    gCpu = 0; gVid = 0;
    if (mBusy == 0) begin
      if (cpu_req && vid_req) begin
        if (mWait >= MAXW) gVid = 1;
        else if (mLastVid) gCpu = 1;
        else gVid = 1;
      end else if (cpu_req) gCpu = 1;
      else if (vid_req) gVid = 1;
    end
    if (!vid_req || gVid) mWait = 0;
    else if (!(mBusy > 0 && mOwnerVid)) mWait = (mWait < MAXW) ? mWait + 1 : MAXW;
    if (mBusy > 0) begin
      mBusy--;
      if (mBusy == 0) begin
        mLastVid = mOwnerVid;
        if (!mIsWrite) begin
          if (mOwnerVid) expVidData = mData;
          else expCpuData = mData;
        end
      end
    end else if (gCpu || gVid) begin
      mBusy = 2;
      mOwnerVid = gVid;
      mIsWrite = gCpu && cpu_we;
      expMemAddr = gCpu ? cpu_address : vid_address;
      expMemWe = mIsWrite;
      if (mIsWrite) modelMem[cpu_address[8:0]] = cpu_data_o;
      mData = modelMem[expMemAddr[8:0]];
      t.isVid = gVid; t.isWrite = mIsWrite; t.data = mData; t.ackEdge = edgeCnt + 2;
      expQ.push_back(t);
    end
    expBusy = (mBusy > 0);
  endtask

  // Run the reference model on every rising edge from the inputs it samples.
  initial begin
    for (int i = 0; i < 512; i++) modelMem[i] = initVal(i);
    forever begin
      @(posedge clock);
      modelStep();
    end
  end

  // Monitor: between edges compare the registered outputs with the model and
  // pop the scoreboard whenever the DUT presents an ack.
  always @(negedge clock) begin
    if (edgeCnt > 0) begin
      checkOutput("busy", 32'(busy), 32'(expBusy));
      checkOutput("mem_we", 32'(mem_we), 32'(expMemWe));
      checkOutput("mem_address", 32'(mem_address), 32'(expMemAddr));
      checkOutput("cpu_data_i_held", 32'(cpu_data_i), 32'(expCpuData));
      checkOutput("vid_data_held", 32'(vid_data), 32'(expVidData));
      if (cpu_ack || vid_ack) begin
        checkOutput("ack_exclusive", 32'(cpu_ack && vid_ack), 32'(0));
        if (expQ.size() == 0) begin
          checkOutput("unexpected_ack", 32'({cpu_ack, vid_ack}), 32'(0));
        end else begin
          exp_t t;
          t = expQ.pop_front();
          checkOutput("ack_owner_vid", 32'(vid_ack), 32'(t.isVid));
          checkOutput("ack_edge", 32'(edgeCnt), 32'(t.ackEdge));
          if (!t.isWrite) begin
            if (t.isVid) checkOutput("vid_read_data", 32'(vid_data), 32'(t.data));
            else checkOutput("cpu_read_data", 32'(cpu_data_i), 32'(t.data));
          end
        end
      end else if (expQ.size() > 0 && expQ[0].ackEdge <= edgeCnt) begin
        exp_t t;
        t = expQ.pop_front();
        checkOutput("missing_ack_edge", 32'(edgeCnt), 32'(t.ackEdge - 1));
      end
    end
  end

  task automatic applyStimulus(input logic cr, input logic cw, input logic [15:0] ca,
                               input logic [7:0] cd, input logic vr, input logic [15:0] va);
    cpu_req = cr; cpu_we = cw; cpu_address = ca; cpu_data_o = cd;
    vid_req = vr; vid_address = va;
  endtask

  // Wait (bounded) for the chosen port's ack; returns at the negedge it is seen.
  task automatic waitForAck(input bit vid, input int limit);
    for (int n = 0; n < limit; n++) begin
      @(negedge clock);
      if (vid ? vid_ack : cpu_ack) return;
    end
    checks++;
    failures++;
    $display("[TB] FAIL ack_timeout: no %s ack within %0d cycles, expected one", vid ? "vid" : "cpu", limit);
  endtask

  task automatic cpuAccess(input logic we, input logic [15:0] addr, input logic [7:0] data);
    @(negedge clock);
    applyStimulus(1, we, addr, data, vid_req, vid_address);
    waitForAck(0, 20);
    cpu_req = 0;
  endtask

  task automatic doReset();
    @(negedge clock);
    reset_n = 0;
    repeat (2) @(negedge clock);
    reset_n = 1;
  endtask

  task automatic newCpu();
    cpu_we = 1'($urandom_range(0, 1));
    cpu_address = 16'($urandom_range(0, 15));
    cpu_data_o = 8'($urandom);
  endtask

  initial begin
    int ackCount, lastAck;
    reset_n = 0;
    applyStimulus(0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clock);
    reset_n = 1;

    // Write then read back 0x0100.
    cpuAccess(1, 16'h0100, 8'h5A);
    cpuAccess(0, 16'h0100, 8'h00);
    checkOutput("readback_0100", 32'(cpu_data_i), 32'h5A);

    // Simultaneous requests straight after reset, held so grants alternate.
    doReset();
    applyStimulus(1, 0, 16'h0005, 0, 1, 16'h0006);
    repeat (13) @(negedge clock);
    applyStimulus(0, 0, 0, 0, 0, 0);
    repeat (6) @(negedge clock);

    // Reset lands on the edge that ends ACC of a CPU write; re-request after.
    @(negedge clock);
    applyStimulus(1, 1, 16'h0020, 8'hC3, 0, 0);
    @(negedge clock);
    reset_n = 0;
    @(negedge clock);
    reset_n = 1;
    checkOutput("reset_busy", 32'(busy), 32'(0));
    checkOutput("reset_cpu_data", 32'(cpu_data_i), 32'(0));
    waitForAck(0, 20);
    cpu_req = 0;
    cpuAccess(0, 16'h0020, 8'h00);

    // Video sweep 0x0000..0x000F with vid_req held across acks.
    @(negedge clock);
    applyStimulus(0, 0, 0, 0, 1, 16'h0000);
    ackCount = 0;
    lastAck = 0;
    for (int n = 0; n < 100 && ackCount < 16; n++) begin
      @(negedge clock);
      if (vid_ack) begin
        if (ackCount > 0) checkOutput("vid_ack_spacing", 32'(edgeCnt - lastAck), 32'(3));
        lastAck = edgeCnt;
        ackCount++;
        if (ackCount < 16) vid_address = vid_address + 16'd1;
        else vid_req = 0;
      end
    end
    checkOutput("vid_sweep_count", 32'(ackCount), 32'(16));
    vid_req = 0;

    // CPU write immediately followed by a video read of the same address.
    @(negedge clock);
    applyStimulus(1, 1, 16'h0033, 8'h9E, 0, 0);
    waitForAck(0, 20);
    applyStimulus(0, 0, 0, 0, 1, 16'h0033);
    waitForAck(1, 20);
    vid_req = 0;
    checkOutput("write_then_vid_read", 32'(vid_data), 32'h9E);

    // Random traffic with occasional early request drops and reset pulses.
    for (int c = 0; c < 2000; c++) begin
      @(negedge clock);
      if (!reset_n) reset_n = 1;
      else if ($urandom_range(0, 199) == 0) reset_n = 0;
      if (cpu_req) begin
        if (cpu_ack) begin
          if ($urandom_range(0, 1) == 1) cpu_req = 0;
          else newCpu();
        end else if ($urandom_range(0, 39) == 0) cpu_req = 0;
      end else if ($urandom_range(0, 9) < 4) begin
        cpu_req = 1;
        newCpu();
      end
      if (vid_req) begin
        if (vid_ack) begin
          if ($urandom_range(0, 1) == 1) vid_req = 0;
          else vid_address = 16'($urandom_range(0, 15));
        end else if ($urandom_range(0, 39) == 0) vid_req = 0;
      end else if ($urandom_range(0, 9) < 4) begin
        vid_req = 1;
        vid_address = 16'($urandom_range(0, 15));
      end
    end

    @(negedge clock);
    reset_n = 1;
    applyStimulus(0, 0, 0, 0, 0, 0);
    repeat (8) @(negedge clock);
    checkOutput("scoreboard_drained", 32'(expQ.size()), 32'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
